// File: rtl/proj_qsys_led_fader.sv
// proj_qsys_led_fader: Avalon-MM LED stage between the PIO out_port and the LEDs.
// When enabled, every lit LED is PWM-dimmed to one shared 8-bit level.
// When disabled, the LEDs are a registered copy of the PIO pattern.
// The optional fade engine (macro LED_FADER_FADE_EN) ramps the level toward TARGET
// by one step per PWM period. Without the macro, LEVEL follows TARGET.
// Ports: clk, reset_n (sync, active-low); Avalon slave address/chipselect/write_n/
//        writedata/readdata (0 CTRL, 1 TARGET, 2 PRESCALE, 3 STATUS);
//        led_in (PIO pattern), led_out (registered LED drive).
module proj_qsys_led_fader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out
);
    logic        wr, ctrl_wr, presc_wr, en_clr, tick, ctrl_fade, unused_wdata;
    logic        en_q;
    logic [7:0]  target_q, level_q, level_d, pwm_cnt_q, pwm_cnt_d, led_out_q, led_out_d;
    logic [15:0] prescale_q, presc_cnt_q, presc_cnt_d;
    logic [1:0]  status_state;

    assign wr           = chipselect && !write_n;
    assign ctrl_wr      = wr && address == 2'd0;
    assign presc_wr     = wr && address == 2'd2;
    // An EN-clearing write takes effect on its own edge for counters and FSM.
    assign en_clr       = ctrl_wr && !writedata[0];
    assign tick         = en_q && presc_cnt_q == prescale_q;
    assign unused_wdata = ^{writedata[31:16], writedata[1]};

    assign presc_cnt_d = (!en_q || en_clr || presc_wr || tick) ? 16'd0 : presc_cnt_q + 16'd1;
    assign pwm_cnt_d   = (!en_q || en_clr) ? 8'd0 : pwm_cnt_q + {7'd0, tick};
    assign led_out_d   = en_q ? (led_in & {8{pwm_cnt_q < level_q}}) : led_in;
    assign led_out     = led_out_q;

`ifdef LED_FADER_FADE_EN
    localparam logic [1:0] IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10;
    logic       fade_q, wrap, lt, gt;
    logic [1:0] state_q, state_d;

    assign wrap = tick && pwm_cnt_q == 8'hFF;
    assign lt   = level_q < target_q;
    assign gt   = level_q > target_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fade_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            if (ctrl_wr) fade_q <= writedata[1];
            state_q <= state_d;
        end
    end

    // IDLE only picks a direction; UP/DOWN step and re-pick each wrap,
    // so a target that crosses the level reverses without overshoot.
    always_comb begin
        state_d = state_q;
        if (!en_q || en_clr || !fade_q)
            state_d = IDLE;
        else if (wrap)
            state_d = lt ? ((state_q == IDLE || level_q + 8'd1 != target_q) ? UP : IDLE) :
                      gt ? ((state_q == IDLE || level_q - 8'd1 != target_q) ? DOWN : IDLE) : IDLE;
    end

    always_comb begin
        level_d = level_q;
        if (!fade_q)
            level_d = target_q;
        else if (wrap && !en_clr && state_q != IDLE)
            level_d = lt ? level_q + 8'd1 : gt ? level_q - 8'd1 : level_q;
    end

    assign status_state = state_q;
    assign ctrl_fade    = fade_q;
`else
    assign level_d      = target_q;
    assign status_state = 2'b00;
    assign ctrl_fade    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q        <= 1'b0;
            target_q    <= 8'd0;
            prescale_q  <= 16'd0;
            presc_cnt_q <= 16'd0;
            pwm_cnt_q   <= 8'd0;
            level_q     <= 8'd0;
            led_out_q   <= 8'd0;
        end else begin
            if (ctrl_wr) en_q <= writedata[0];
            if (wr && address == 2'd1) target_q <= writedata[7:0];
            if (presc_wr) prescale_q <= writedata[15:0];
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            level_q     <= level_d;
            led_out_q   <= led_out_d;
        end
    end

    always_comb
        readdata = address == 2'd0 ? {30'd0, ctrl_fade, en_q} :
                   address == 2'd1 ? {24'd0, target_q} :
                   address == 2'd2 ? {16'd0, prescale_q} :
                                     {22'd0, status_state, level_q};
endmodule

// File: tb/tb_proj_qsys_led_fader.sv
// tb_proj_qsys_led_fader: directed self-checking bench for proj_qsys_led_fader.
module tb_proj_qsys_led_fader;
    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

`ifdef LED_FADER_FADE_EN
    localparam logic [31:0] CTRL3 = 32'h3;
`else
    localparam logic [31:0] CTRL3 = 32'h1;
`endif

    logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = 32'd0, readdata;
    logic [7:0]  led_in = 8'd0, led_out;
    int          checks = 0, failures = 0;
    vec_t        vecs[10];

    always #5 clk = ~clk;

    proj_qsys_led_fader dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .led_in(led_in), .led_out(led_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; spans exactly one rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1 d = readdata;
    endtask

    // Waits (bounded) for STATUS to change; optionally checks the cycle distance.
    task automatic wait_status(input string name, input logic [31:0] exp, input int exp_cyc);
        logic [31:0] prev, cur;
        int n;
        n = 0;
        rd(2'd3, prev);
        do begin
            @(negedge clk);
            n++;
            rd(2'd3, cur);
        end while (cur == prev && n < 2000);
        check({name, "_status"}, cur, exp);
        if (exp_cyc > 0) check({name, "_cycles"}, n, exp_cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int on, last_on;
        vecs = '{
            '{1'b0, 2'd0, 32'h0,         32'h0},
            '{1'b0, 2'd1, 32'h0,         32'h0},
            '{1'b0, 2'd2, 32'h0,         32'h0},
            '{1'b0, 2'd3, 32'h0,         32'h0},
            '{1'b1, 2'd1, 32'hFFFF_FF5A, 32'h5A},
            '{1'b1, 2'd2, 32'hABCD_1234, 32'h1234},
            '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h5A},
            '{1'b1, 2'd0, 32'h3,         CTRL3},
            '{1'b1, 2'd0, 32'h0,         32'h0},
            '{1'b1, 2'd2, 32'h0,         32'h0}
        };
        led_in = 8'hA5;
        repeat (3) @(negedge clk);
        check("reset_led_out", {24'd0, led_out}, 32'h00);
        reset_n = 1'b1;
        @(negedge clk);
        check("passthrough", {24'd0, led_out}, 32'hA5);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            check($sformatf("reg_vec%0d", i), r, vecs[i].exp);
        end
        wr(2'd1, 32'd200);
        @(negedge clk);
        rd(2'd3, r);
        check("level_tracks_target", r, 32'hC8);
        led_in = 8'hFF;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd64);
        wr(2'd0, 32'h1);
        on = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (led_out == 8'hFF) on++;
            if (k == 1) check("pwm64_first_on", {24'd0, led_out}, 32'hFF);
            if (k == 65) check("pwm64_first_off", {24'd0, led_out}, 32'h00);
        end
        check("pwm64_on_count", on, 64);
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd128);
        wr(2'd0, 32'h0);
        wr(2'd0, 32'h1);
        repeat (2) @(negedge clk);
        wr(2'd2, 32'd3);
        on = 0;
        last_on = 0;
        for (int k = 4; k <= 1024; k++) begin
            @(negedge clk);
            if (led_out == 8'hFF) begin
                on++;
                last_on = k;
            end
        end
        check("presc3_on_count", on, 512);
        check("presc_rewrite_last_on", last_on, 515);
        led_in = 8'h3C;
        wr(2'd0, 32'h0);
        rd(2'd3, r);
        check("en_clear_level_held", r, 32'h80);
        @(negedge clk);
        check("en_clear_passthrough", {24'd0, led_out}, 32'h3C);
`ifdef LED_FADER_FADE_EN
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd0);
        @(negedge clk);
        wr(2'd0, 32'h3);
        wr(2'd1, 32'd4);
        wait_status("fade_up_start", 32'h100, 0);
        wait_status("fade_l1", 32'h101, 256);
        wait_status("fade_l2", 32'h102, 256);
        wait_status("fade_l3", 32'h103, 256);
        wait_status("fade_l4_idle", 32'h004, 256);
        wr(2'd1, 32'd8);
        wait_status("fade2_up", 32'h104, 0);
        wait_status("fade2_l5", 32'h105, 256);
        wait_status("fade2_l6", 32'h106, 256);
        wr(2'd1, 32'd3);
        wait_status("reverse_l5", 32'h205, 0);
        wait_status("reverse_l4", 32'h204, 256);
        wait_status("reverse_l3_idle", 32'h003, 256);
        wr(2'd1, 32'd10);
        wait_status("fade3_up", 32'h103, 0);
        wait_status("fade3_l4", 32'h104, 256);
        wr(2'd0, 32'h2);
        rd(2'd3, r);
        check("fade_en_clear_idle", r, 32'h004);
        @(negedge clk);
        check("fade_en_clear_passthrough", {24'd0, led_out}, 32'h3C);
        repeat (300) @(negedge clk);
        rd(2'd3, r);
        check("fade_en_clear_hold", r, 32'h004);
        wr(2'd0, 32'h3);
        wait_status("fade4_up", 32'h104, 0);
`else
        wr(2'd0, CTRL3);
        wr(2'd1, 32'd77);
        repeat (5) @(negedge clk);
`endif
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, r);
        check("reset_ctrl", r, 32'h0);
        rd(2'd1, r);
        check("reset_target", r, 32'h0);
        rd(2'd3, r);
        check("reset_status", r, 32'h0);
        check("reset_led_out2", {24'd0, led_out}, 32'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
